sram_owner_ctrl: RTL
====================

SRAM_OWNER_CTRL -- requirements
Module: sram_owner_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 3, idle cycles between ownership change and new grant (legal range 2..15).
REQ-002 SHALL have parameter SOPC_MIN_SLOT, default 8, cycles SOPC keeps ownership after regaining it before tr_req is honoured again (0 = none).
REQ-003 SHALL have parameter STARVE_LIMIT, default 1024, consecutive stalled-SOPC-request cycles that raise sopc_starved.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 sopc_read  input  1  SOPC master read strobe (monitored).
REQ-007 sopc_write  input  1  SOPC master write strobe (monitored).
REQ-008 tr_req  input  1  test runner requests SRAM ownership; level, held while owned.
REQ-009 tr_read  input  1  test runner read strobe (monitored).
REQ-010 tr_write  input  1  test runner write strobe (monitored).
REQ-011 sel  output  1  registered master select to SRAM arbiter; 0 = SOPC, 1 = test runner.
REQ-012 sopc_stall  output  1  registered; ORed by top level into SOPC waitrequest.
REQ-013 tr_gnt  output  1  registered; test runner may issue accesses only while high.
REQ-014 sopc_starved  output  1  registered starvation flag.
REQ-015 grant_count  output  16  registered saturating count of entries into TR state.

Function
REQ-016 SHALL implement states SOPC, DRAIN_TO_TR, TR, DRAIN_TO_SOPC, with a 4-bit drain counter and a slot counter sized for SOPC_MIN_SLOT.
REQ-017 SOPC: sel=0, sopc_stall=0, tr_gnt=0; go to DRAIN_TO_TR when tr_req=1, sopc_read=0, sopc_write=0 and slot counter expired; load drain counter with DRAIN_CYCLES.
REQ-018 SOPC strobe active in the same cycle as tr_req SHALL win; transition deferred to first idle SOPC cycle.
REQ-019 DRAIN_TO_TR: sel=0, sopc_stall=1, tr_gnt=0; counter decrements each cycle; at count 1 go to TR.
REQ-020 tr_req falling during DRAIN_TO_TR SHALL abort to SOPC next cycle (stall low, slot counter not loaded, grant_count unchanged).
REQ-021 TR: sel=1, tr_gnt=1, sopc_stall=1; sel and tr_gnt rise on the same edge; grant_count increments on entry, saturating at 16'hFFFF.
REQ-022 TR: go to DRAIN_TO_SOPC when tr_req=0, tr_read=0, tr_write=0; tr_req=0 with a strobe still active SHALL hold TR.
REQ-023 DRAIN_TO_SOPC: sel=1, tr_gnt=0, sopc_stall=1; DRAIN_CYCLES cycles, then SOPC with slot counter loaded with SOPC_MIN_SLOT.
REQ-024 Slot counter SHALL decrement only in SOPC, stop at 0; tr_req ignored while non-zero.
REQ-025 sel SHALL never change while any monitored strobe of the outgoing owner was active within the last DRAIN_CYCLES cycles.
REQ-026 Starve counter: increments each cycle sopc_stall=1 and (sopc_read|sopc_write)=1, clears when that condition is false; saturates at STARVE_LIMIT.
REQ-027 sopc_starved SHALL set the cycle after the starve counter reaches STARVE_LIMIT and stay set until state enters SOPC.
REQ-028 Outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-029 reset_n low SHALL immediately force state SOPC, sel=0, sopc_stall=0, tr_gnt=0, sopc_starved=0, grant_count=0, all counters 0.
REQ-030 Reset asserted mid-TR or mid-drain SHALL return ownership to SOPC without waiting for drain; release SHALL take effect on the first rising edge with reset_n high.

Verification
REQ-031 SOPC idle, tr_req rises at cycle 0 -> sopc_stall=1 at cycle 1, sel=1 and tr_gnt=1 at cycle 4 (DRAIN_CYCLES=3), grant_count=1.
REQ-032 sopc_read held cycles 0-4, tr_req from cycle 0 -> sopc_stall stays 0 until cycle 6; sel=1 at cycle 9.
REQ-033 In TR, tr_req drops at cycle 0 while tr_write high until cycle 2 -> tr_gnt falls cycle 3, sel=0 and sopc_stall=0 at cycle 6; tr_req re-raised immediately not honoured until 8 SOPC cycles elapse.
REQ-034 tr_req drops in cycle 2 of DRAIN_TO_TR -> sopc_stall=0 next cycle, sel never 1, grant_count unchanged.
REQ-035 STARVE_LIMIT=16, TR held, sopc_write held 16 cycles -> sopc_starved=1 on 17th cycle; clears when SOPC re-entered.
REQ-036 reset_n pulsed low mid-TR -> sel=0, tr_gnt=0, grant_count=0 asynchronously, before next clock edge.

Source files
------------

// File: rtl/sram_owner_ctrl.sv
// sram_owner_ctrl: hands SRAM ownership between the SOPC master and the test runner with drain gaps, a minimum SOPC slot and starvation flagging.
module sram_owner_ctrl #(
    parameter int DRAIN_CYCLES  = 3,
    parameter int SOPC_MIN_SLOT = 8,
    parameter int STARVE_LIMIT  = 1024
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        sopc_read,
    input  logic        sopc_write,
    input  logic        tr_req,
    input  logic        tr_read,
    input  logic        tr_write,
    output logic        sel,
    output logic        sopc_stall,
    output logic        tr_gnt,
    output logic        sopc_starved,
    output logic [15:0] grant_count
);
    localparam int SW  = SOPC_MIN_SLOT > 0 ? $clog2(SOPC_MIN_SLOT + 1) : 1;
    localparam int STW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {SOPC, DRAIN_TO_TR, TR, DRAIN_TO_SOPC} state_t;

    state_t         state, state_nxt;
    logic [3:0]     drain_cnt, drain_nxt;
    logic [SW-1:0]  slot_cnt, slot_nxt;
    logic [STW-1:0] starve_cnt, starve_nxt;
    logic           sopc_busy, tr_busy;

    assign sopc_busy = sopc_read | sopc_write;
    assign tr_busy   = tr_read | tr_write;

    always_comb begin
        state_nxt  = state;
        drain_nxt  = drain_cnt;
        slot_nxt   = slot_cnt;
        starve_nxt = (sopc_stall && sopc_busy) ?
                     (starve_cnt == STW'(STARVE_LIMIT) ? starve_cnt : starve_cnt + STW'(1)) : '0;
        case (state)
            SOPC: begin
                slot_nxt = slot_cnt != '0 ? slot_cnt - SW'(1) : slot_cnt;
                if (tr_req && !sopc_busy && slot_cnt == '0) begin
                    state_nxt = DRAIN_TO_TR;
                    drain_nxt = 4'(DRAIN_CYCLES);
                end
            end
            DRAIN_TO_TR: begin
                if (!tr_req)
                    state_nxt = SOPC;
                else if (drain_cnt == 4'd1)
                    state_nxt = TR;
                else
                    drain_nxt = drain_cnt - 4'd1;
            end
            TR: begin
                if (!tr_req && !tr_busy) begin
                    state_nxt = DRAIN_TO_SOPC;
                    drain_nxt = 4'(DRAIN_CYCLES);
                end
            end
            DRAIN_TO_SOPC: begin
                // a stray runner strobe restarts the gap so sel never flips right behind it
                if (tr_busy)
                    drain_nxt = 4'(DRAIN_CYCLES);
                else if (drain_cnt == 4'd1) begin
                    state_nxt = SOPC;
                    slot_nxt  = SW'(SOPC_MIN_SLOT);
                end else
                    drain_nxt = drain_cnt - 4'd1;
            end
            default: state_nxt = SOPC;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= SOPC;
            drain_cnt    <= '0;
            slot_cnt     <= '0;
            starve_cnt   <= '0;
            sel          <= 1'b0;
            sopc_stall   <= 1'b0;
            tr_gnt       <= 1'b0;
            sopc_starved <= 1'b0;
            grant_count  <= '0;
        end else begin
            state        <= state_nxt;
            drain_cnt    <= drain_nxt;
            slot_cnt     <= slot_nxt;
            starve_cnt   <= starve_nxt;
            sel          <= state_nxt inside {TR, DRAIN_TO_SOPC};
            sopc_stall   <= state_nxt != SOPC;
            tr_gnt       <= state_nxt == TR;
            sopc_starved <= state_nxt != SOPC && (sopc_starved || starve_nxt == STW'(STARVE_LIMIT));
            if (state_nxt == TR && state != TR && grant_count != 16'hFFFF)
                grant_count <= grant_count + 16'd1;
        end
    end
endmodule
